// File: rtl/pcm_frame_receiver.sv
// pcm_frame_receiver: receives raw-Ethernet PCM packets into the back half of a
// double buffer and plays the front half out one 16-channel frame per play_stb.
// A packet becomes playable only after a clean end-of-frame; playback swaps
// halves lazily on the first play_stb that finds the front half empty.
module pcm_frame_receiver #(
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int          NFRAMES   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_start,
    input  logic        rx_stb,
    input  logic [7:0]  rx_data,
    input  logic        rx_end,
    input  logic        rx_crc_ok,
    input  logic        play_stb,
    output logic        pcm_stb,
    output logic [3:0]  pcm_chan,
    output logic [15:0] pcm_data,
    output logic        underrun,
    output logic [7:0]  frames_ok,
    output logic [7:0]  frames_bad
);

    localparam int PAYLOAD = NFRAMES * 32;
    localparam int MIN_LEN = 14 + PAYLOAD;
    localparam int FP_W    = $clog2(NFRAMES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SWAP,
        S_READ_LO,
        S_READ_HI,
        S_EMIT
    } state_t;

    // ---------------------------------------------------------------- state
    state_t            r_state;
    state_t            w_state_next;

    logic              r_rx_active;
    logic [15:0]       r_rx_idx;
    logic [7:0]        r_et_hi;
    logic              r_et_ok;
    logic              r_back_ready;
    logic              r_front_sel;
    logic [7:0]        r_frames_ok;
    logic [7:0]        r_frames_bad;

    logic [FP_W-1:0]   r_frame_ptr;
    logic [3:0]        r_chan;
    logic [7:0]        r_lo;
    logic [15:0]       r_hold_data;
    logic [3:0]        r_hold_chan;
    logic              r_underrun;

    logic [7:0]        r_mem [0:1023];
    logic [7:0]        r_rd_data;

    // ---------------------------------------------------------------- RX decode
    logic              w_rx_byte;
    logic              w_wr_en;
    logic [8:0]        w_wr_off;
    logic [9:0]        w_wr_addr;
    logic              w_frame_end;
    logic              w_good;
    logic              w_bad;

    // rx_start in the same cycle as a byte wins: the byte belongs to nothing
    assign w_rx_byte   = rx_stb & r_rx_active & ~rx_start;
    assign w_wr_en     = w_rx_byte && (r_rx_idx >= 16'd14) && (r_rx_idx < 16'(MIN_LEN));
    assign w_wr_off    = 9'(r_rx_idx - 16'd14);
    assign w_wr_addr   = {~r_front_sel, w_wr_off};
    assign w_frame_end = rx_end & r_rx_active;
    assign w_good      = w_frame_end & rx_crc_ok & r_et_ok & (r_rx_idx >= 16'(MIN_LEN));
    assign w_bad       = w_frame_end & ~w_good;

    // ---------------------------------------------------------------- playback decode
    logic              w_front_avail;
    logic              w_rd_hi;
    logic [8:0]        w_rd_off;
    logic [9:0]        w_rd_addr;

    assign w_front_avail = (r_frame_ptr != FP_W'(NFRAMES));
    assign w_rd_hi       = (r_state == S_READ_HI);
    assign w_rd_off      = (9'(r_frame_ptr) << 5) | {4'd0, r_chan, w_rd_hi};
    assign w_rd_addr     = {r_front_sel, w_rd_off};

    // Byte tracking for the frame being received: index, EtherType match
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_active <= 1'b0;
            r_rx_idx    <= 16'd0;
            r_et_hi     <= 8'd0;
            r_et_ok     <= 1'b0;
        end else if (rx_start) begin
            r_rx_active <= 1'b1;
            r_rx_idx    <= 16'd0;
            r_et_ok     <= 1'b0;
        end else begin
            if (w_rx_byte) begin
                if (r_rx_idx != 16'hFFFF)
                    r_rx_idx <= r_rx_idx + 16'd1;
                if (r_rx_idx == 16'd12)
                    r_et_hi <= rx_data;
                if (r_rx_idx == 16'd13)
                    r_et_ok <= ({r_et_hi, rx_data} == ETHERTYPE);
            end
            if (w_frame_end)
                r_rx_active <= 1'b0;
        end
    end

    // Saturating good/bad frame counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frames_ok  <= 8'd0;
            r_frames_bad <= 8'd0;
        end else begin
            if (w_good && r_frames_ok != 8'hFF)
                r_frames_ok <= r_frames_ok + 8'd1;
            if (w_bad && r_frames_bad != 8'hFF)
                r_frames_bad <= r_frames_bad + 8'd1;
        end
    end

    // Back half ownership: a new frame invalidates it, a good end validates it,
    // a swap hands it to playback. Swaps cannot occur mid-reception because
    // rx_start has already cleared back_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_back_ready <= 1'b0;
            r_front_sel  <= 1'b0;
        end else begin
            if (rx_start || r_state == S_SWAP)
                r_back_ready <= 1'b0;
            else if (w_good)
                r_back_ready <= 1'b1;
            if (r_state == S_SWAP)
                r_front_sel <= ~r_front_sel;
        end
    end

    // Double-buffer RAM: RX writes the back half, playback reads the front half
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[w_wr_addr] <= rx_data;
        r_rd_data <= r_mem[w_rd_addr];
    end

    // Playback FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Playback FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (play_stb) begin
                    if (w_front_avail)
                        w_state_next = S_READ_LO;
                    else if (r_back_ready)
                        w_state_next = S_SWAP;
                end
            end
            S_SWAP:    w_state_next = S_READ_LO;
            S_READ_LO: w_state_next = S_READ_HI;
            S_READ_HI: w_state_next = S_EMIT;
            S_EMIT:    w_state_next = (r_chan == 4'd15) ? S_IDLE : S_READ_LO;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Playback datapath: frame/channel pointers, byte capture, output hold, underrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_ptr <= FP_W'(NFRAMES);
            r_chan      <= 4'd0;
            r_lo        <= 8'd0;
            r_hold_data <= 16'd0;
            r_hold_chan <= 4'd0;
            r_underrun  <= 1'b0;
        end else begin
            r_underrun <= (r_state == S_IDLE) && play_stb && !w_front_avail && !r_back_ready;
            case (r_state)
                S_IDLE:    r_chan      <= 4'd0;
                S_SWAP:    r_frame_ptr <= '0;
                S_READ_HI: r_lo        <= r_rd_data;
                S_EMIT: begin
                    r_hold_data <= {r_rd_data, r_lo};
                    r_hold_chan <= r_chan;
                    if (r_chan == 4'd15)
                        r_frame_ptr <= r_frame_ptr + FP_W'(1);
                    else
                        r_chan <= r_chan + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // The sample is presented straight from the RAM during EMIT, then held
    assign pcm_stb    = (r_state == S_EMIT);
    assign pcm_chan   = pcm_stb ? r_chan : r_hold_chan;
    assign pcm_data   = pcm_stb ? {r_rd_data, r_lo} : r_hold_data;
    assign underrun   = r_underrun;
    assign frames_ok  = r_frames_ok;
    assign frames_bad = r_frames_bad;

endmodule

// File: tb/tb_pcm_frame_receiver.sv
// Bench for pcm_frame_receiver: stimulus pushes expected PCM samples / underruns
// into a queue, a negedge monitor pops and compares whenever the DUT emits.
module tb_pcm_frame_receiver;

    localparam logic [15:0] ET   = 16'h88B5;
    localparam int          GOOD = 14 + 16 * 32 + 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_start, rx_stb, rx_end, rx_crc_ok, play_stb;
    logic [7:0]  rx_data;
    logic        pcm_stb, underrun;
    logic [3:0]  pcm_chan;
    logic [15:0] pcm_data;
    logic [7:0]  frames_ok, frames_bad;

    typedef struct {
        bit          und;
        logic [3:0]  chan;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    pcm_frame_receiver #(.ETHERTYPE(ET), .NFRAMES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_start(rx_start), .rx_stb(rx_stb), .rx_data(rx_data),
        .rx_end(rx_end), .rx_crc_ok(rx_crc_ok), .play_stb(play_stb),
        .pcm_stb(pcm_stb), .pcm_chan(pcm_chan), .pcm_data(pcm_data),
        .underrun(underrun), .frames_ok(frames_ok), .frames_bad(frames_bad)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every output event must match the head of the expectation queue
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && (pcm_stb || underrun)) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got stb=%0b und=%0b chan=%0d data=%h expected none",
                             pcm_stb, underrun, pcm_chan, pcm_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_kind", {31'd0, underrun}, {31'd0, mon_e.und});
                    if (!mon_e.und) begin
                        check("pcm_chan", {28'd0, pcm_chan}, {28'd0, mon_e.chan});
                        check("pcm_data", {16'd0, pcm_data}, {16'd0, mon_e.data});
                    end
                end
            end
        end
    end

    // Send one frame: header filler, EtherType, payload byte k = k + base, then FCS/padding
    task automatic send_frame(input logic [15:0] et, input int len, input bit crc,
                              input logic [7:0] base, input bit finish, input bit quiet);
        logic [7:0] b;
        rx_start = 1'b1;
        tick(1);
        rx_start = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (i < 12)       b = 8'hA5;
            else if (i == 12) b = et[15:8];
            else if (i == 13) b = et[7:0];
            else              b = 8'(i - 14) + base;
            rx_stb  = 1'b1;
            rx_data = b;
            tick(1);
            rx_stb = 1'b0;
            if (i % 7 == 3) tick(1);
        end
        if (finish) begin
            rx_end    = 1'b1;
            rx_crc_ok = crc;
            tick(1);
            rx_end    = 1'b0;
            rx_crc_ok = 1'b0;
        end
        tick(2);
        if (!quiet)
            $display("frame et=%h len=%0d crc=%0b base=%h end=%0b -> ok=%0d bad=%0d",
                     et, len, crc, base, finish, frames_ok, frames_bad);
    endtask

    // One play_stb: expect either an underrun or frame f of a packet with the given base
    task automatic play(input int f, input logic [7:0] base, input bit und, input bit extra_stb);
        exp_t e;
        logic [7:0] lo, hi;
        if (und) begin
            e.und = 1'b1; e.chan = 4'd0; e.data = 16'd0;
            exp_q.push_back(e);
        end else begin
            for (int c = 0; c < 16; c++) begin
                lo = 8'(f * 32 + 2 * c) + base;
                hi = 8'(f * 32 + 2 * c + 1) + base;
                e.und = 1'b0; e.chan = 4'(c); e.data = {hi, lo};
                exp_q.push_back(e);
            end
        end
        play_stb = 1'b1;
        tick(1);
        play_stb = 1'b0;
        if (extra_stb) begin
            tick(5);
            play_stb = 1'b1;
            tick(1);
            play_stb = 1'b0;
        end
        tick(60);
        check("queue_drained", exp_q.size(), 32'd0);
        exp_q.delete();
        $display("play frame=%0d base=%h underrun_expected=%0b", f, base, und);
    endtask

    initial begin
        rst_n = 1'b0; rx_start = 1'b0; rx_stb = 1'b0; rx_data = 8'd0;
        rx_end = 1'b0; rx_crc_ok = 1'b0; play_stb = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        check("rst_pcm_stb",    {31'd0, pcm_stb},    32'd0);
        check("rst_pcm_chan",   {28'd0, pcm_chan},   32'd0);
        check("rst_pcm_data",   {16'd0, pcm_data},   32'd0);
        check("rst_underrun",   {31'd0, underrun},   32'd0);
        check("rst_frames_ok",  {24'd0, frames_ok},  32'd0);
        check("rst_frames_bad", {24'd0, frames_bad}, 32'd0);

        play(0, 8'h00, 1'b1, 1'b0);

        send_frame(ET, GOOD, 1'b0, 8'h00, 1'b1, 1'b0);
        check("crc_bad_cnt", {24'd0, frames_bad}, 32'd1);
        check("crc_ok_cnt",  {24'd0, frames_ok},  32'd0);
        play(0, 8'h00, 1'b1, 1'b0);

        send_frame(16'h0800, GOOD, 1'b1, 8'h00, 1'b1, 1'b0);
        check("et_bad_cnt", {24'd0, frames_bad}, 32'd2);
        play(0, 8'h00, 1'b1, 1'b0);

        send_frame(ET, 100, 1'b1, 8'h00, 1'b1, 1'b0);
        check("short_bad_cnt", {24'd0, frames_bad}, 32'd3);
        play(0, 8'h00, 1'b1, 1'b0);

        // Good frame: frame 0 chan 0 = 16'h0100, chan 1 = 16'h0302 from the k=k payload
        send_frame(ET, GOOD, 1'b1, 8'h00, 1'b1, 1'b0);
        check("good_ok_cnt", {24'd0, frames_ok}, 32'd1);
        for (int f = 0; f < 16; f++)
            play(f, 8'h00, 1'b0, f == 3);
        play(16, 8'h00, 1'b1, 1'b0);

        // Two good frames before playback: the later one replaces the earlier
        send_frame(ET, GOOD, 1'b1, 8'h40, 1'b1, 1'b0);
        send_frame(ET, GOOD, 1'b1, 8'h80, 1'b1, 1'b0);
        check("two_ok_cnt", {24'd0, frames_ok}, 32'd3);
        play(0, 8'h80, 1'b0, 1'b0);
        play(1, 8'h80, 1'b0, 1'b0);

        // Aborted frame followed by a complete one: only the complete one counts
        send_frame(ET, 50, 1'b1, 8'h22, 1'b0, 1'b0);
        send_frame(ET, GOOD, 1'b1, 8'h11, 1'b1, 1'b0);
        check("abort_ok_cnt",  {24'd0, frames_ok},  32'd4);
        check("abort_bad_cnt", {24'd0, frames_bad}, 32'd3);
        for (int f = 2; f < 16; f++)
            play(f, 8'h80, 1'b0, 1'b0);
        play(0, 8'h11, 1'b0, 1'b0);
        play(1, 8'h11, 1'b0, 1'b0);

        // Saturation of the bad counter
        for (int n = 0; n < 260; n++)
            send_frame(ET, 16, 1'b0, 8'h00, 1'b1, 1'b1);
        check("bad_saturated", {24'd0, frames_bad}, 32'd255);
        check("ok_unchanged",  {24'd0, frames_ok},  32'd4);

        // Reset mid-frame with a partly played front half: everything discarded
        send_frame(ET, 60, 1'b1, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("post_rst_ok",  {24'd0, frames_ok},  32'd0);
        check("post_rst_bad", {24'd0, frames_bad}, 32'd0);
        play(0, 8'h00, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcm_frame_receiver.md
PCM_FRAME_RECEIVER -- requirements
Module: pcm_frame_receiver

Interface
REQ-001 Parameter ETHERTYPE, default 16'h88B5, accepted EtherType, frame bytes 12-13, big-endian.
REQ-002 Parameter NFRAMES, default 16, PCM sample frames per packet; 16 channels per frame; payload = NFRAMES*32 bytes.
REQ-003 clk  in  1  system clock, all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 rx_start  in  1  one-cycle pulse, new Ethernet frame begins (first byte = destination MAC, preamble/SFD already stripped).
REQ-006 rx_stb  in  1  one-cycle pulse, rx_data valid.
REQ-007 rx_data  in  8  received byte.
REQ-008 rx_end  in  1  one-cycle pulse, frame finished; qualifies rx_crc_ok.
REQ-009 rx_crc_ok  in  1  FCS correct; sampled only with rx_end.
REQ-010 play_stb  in  1  one-cycle pulse, one PCM frame due (same rate as the audio PCM strobe).
REQ-011 pcm_stb  out  1  one-cycle pulse, pcm_chan/pcm_data valid.
REQ-012 pcm_chan  out  4  channel index 0..15.
REQ-013 pcm_data  out  16  signed sample.
REQ-014 underrun  out  1  one-cycle pulse, play_stb found no data.
REQ-015 frames_ok / frames_bad  out  8 each  saturating counters.

Function
REQ-016 Internal 1024x8 buffer, two halves (front = playback, back = receive), 1-cycle read latency.
REQ-017 RX byte index counts rx_stb pulses since rx_start; bytes 0-11 ignored, 12-13 compared to ETHERTYPE, bytes 14..14+NFRAMES*32-1 written to back half at offset index-14, later bytes (FCS, padding) ignored.
REQ-018 Payload order: frame f, channel c, low byte at offset f*32+c*2, high byte at +1.
REQ-019 Frame good iff rx_end with rx_crc_ok=1, EtherType match, and byte count >= 14+NFRAMES*32; good -> back_ready<=1, frames_ok+1; otherwise frames_bad+1, back_ready unchanged.
REQ-020 rx_start clears back_ready (back half being overwritten); a good frame arriving while previous back still unconsumed replaces it.
REQ-021 rx_start while a frame in progress aborts it silently (no counter change) and restarts at index 0; rx_stb without prior rx_start ignored.
REQ-022 Playback FSM states: IDLE, SWAP, READ_LO, READ_HI, EMIT.
REQ-023 IDLE + play_stb: if front has remaining frames -> READ_LO; else if back_ready -> SWAP (swap halves, clear back_ready, frame pointer 0) then READ_LO; else underrun pulse, stay IDLE, no pcm_stb.
REQ-024 READ_LO/READ_HI fetch the two bytes of channel c; EMIT drives pcm_stb=1 with pcm_chan=c, pcm_data={hi,lo}; c=15 -> frame pointer+1, IDLE; else next channel READ_LO.
REQ-025 Exactly 16 pcm_stb pulses per served play_stb, channels 0..15 ascending, first within 4 cycles of play_stb, consecutive pulses 3 cycles apart.
REQ-026 play_stb arriving while FSM not IDLE is ignored.
REQ-027 Front exhausted after NFRAMES served frames; back_ready set with front exhausted swaps only on next play_stb.
REQ-028 RX writes and playback reads never target the same half; swap during active reception redirects later RX bytes to the new back half (that frame then cannot be good unless completed, per REQ-020).
REQ-029 Counters saturate at 255.
REQ-030 pcm_data/pcm_chan hold last value between pulses.

Reset
REQ-031 rst_n low: FSM IDLE, back_ready=0, front exhausted, RX idle, pcm_stb=0, pcm_chan=0, pcm_data=0, underrun=0, counters 0; buffer contents undefined, unread until a good frame.
REQ-032 Reset mid-frame or mid-playback discards all state; first post-reset play_stb yields underrun.

Verification
REQ-033 After reset, play_stb -> underrun pulse, no pcm_stb.
REQ-034 Good frame, payload byte k = k[7:0], then 16 play_stb -> frame0 chan0 = 16'h0100, chan1 = 16'h0302, 256 pulses total, 17th play_stb -> underrun.
REQ-035 Frame with rx_crc_ok=0 -> frames_bad=1, frames_ok=0, play_stb -> underrun.
REQ-036 EtherType 16'h0800 or 100-byte frame -> frames_bad increments, back_ready stays 0.
REQ-037 Two good frames (A then B) before play_stb -> playback yields B; frames_ok=2.
REQ-038 rx_start mid-frame, then complete good frame -> frames_ok=1, frames_bad=0, data = second frame.
